// File: rtl/interp_bilinear_pipe.sv
// rtl/interp_bilinear_pipe.sv - four-neighbour bilinear / nearest pixel interpolator, 4-cycle pipeline
module interp_bilinear_pipe #(
    parameter int FRAC_W = 6,
    parameter int PIX_W  = 8,
    parameter int CH     = 1,
    parameter int ROUND  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  logic                  s_mode,
    input  logic [FRAC_W-1:0]     dx,
    input  logic [FRAC_W-1:0]     dy,
    input  logic [CH*PIX_W-1:0]   lu,
    input  logic [CH*PIX_W-1:0]   ru,
    input  logic [CH*PIX_W-1:0]   ld,
    input  logic [CH*PIX_W-1:0]   rd,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [CH*PIX_W-1:0]   m_p
);
    localparam int WW  = FRAC_W + 1;
    localparam int PW  = 2 * FRAC_W + 2;
    localparam int PRW = PIX_W + PW;
    localparam int SW  = PRW + 2;
    localparam int DW  = CH * PIX_W;
    localparam logic [WW-1:0] ONE = WW'(1) << FRAC_W;
    localparam logic [SW-1:0] RND = (ROUND != 0) ? (SW'(1) << (2 * FRAC_W - 1)) : '0;

    logic ce;

    // stage 1: weights, pixels, sideband
    logic                  v1_d, v1_q, last1_d, last1_q;
    logic [WW-1:0]         wx0_d, wx0_q, wx1_d, wx1_q, wy0_d, wy0_q, wy1_d, wy1_q;
    logic [3:0][DW-1:0]    px1_d, px1_q;
    // stage 2: weight products
    logic                  v2_d, v2_q, last2_d, last2_q;
    logic [3:0][PW-1:0]    w2_d, w2_q;
    logic [3:0][DW-1:0]    px2_d, px2_q;
    // stage 3: pixel*weight products per channel
    logic                  v3_d, v3_q, last3_d, last3_q;
    logic [CH-1:0][3:0][PRW-1:0] prod_d, prod_q;
    // stage 4: rounded sums
    logic                  v4_d, v4_q, last4_d, last4_q;
    logic [CH-1:0][SW-1:0] sum_d, sum_q;
    // output register
    logic                  m_valid_d, m_valid_q, m_last_d, m_last_q;
    logic [DW-1:0]         m_p_d, m_p_q;

    assign ce      = !m_valid_q || m_ready;
    assign s_ready = rst_n && ce;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_p     = m_p_q;

    // Nearest mode reuses the multiply path with one-hot weights of 2^FRAC_W,
    // which reproduces the selected neighbour exactly under either rounding.
    always_comb begin
        v1_d    = s_valid;
        last1_d = s_last;
        if (s_mode) begin
            wx1_d = dx[FRAC_W-1] ? ONE : '0;
            wy1_d = dy[FRAC_W-1] ? ONE : '0;
        end else begin
            wx1_d = {1'b0, dx};
            wy1_d = {1'b0, dy};
        end
        wx0_d    = ONE - wx1_d;
        wy0_d    = ONE - wy1_d;
        px1_d[0] = lu;
        px1_d[1] = ru;
        px1_d[2] = ld;
        px1_d[3] = rd;
    end

    always_comb begin
        v2_d    = v1_q;
        last2_d = last1_q;
        w2_d[0] = PW'(wx0_q) * PW'(wy0_q);
        w2_d[1] = PW'(wx1_q) * PW'(wy0_q);
        w2_d[2] = PW'(wx0_q) * PW'(wy1_q);
        w2_d[3] = PW'(wx1_q) * PW'(wy1_q);
        px2_d   = px1_q;
    end

    always_comb begin
        v3_d    = v2_q;
        last3_d = last2_q;
        prod_d  = '0;
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < 4; i++) begin
                prod_d[c][i] = PRW'(px2_q[i][c*PIX_W +: PIX_W]) * PRW'(w2_q[i]);
            end
        end
    end

    always_comb begin
        v4_d    = v3_q;
        last4_d = last3_q;
        sum_d   = '0;
        for (int c = 0; c < CH; c++) begin
            sum_d[c] = SW'(prod_q[c][0]) + SW'(prod_q[c][1])
                     + SW'(prod_q[c][2]) + SW'(prod_q[c][3]) + RND;
        end
    end

    // weights sum to 2^(2*FRAC_W), so the shifted sum always fits PIX_W bits
    always_comb begin
        m_valid_d = v4_q;
        m_last_d  = last4_q;
        m_p_d     = '0;
        for (int c = 0; c < CH; c++) begin
            m_p_d[c*PIX_W +: PIX_W] = PIX_W'(sum_q[c] >> (2 * FRAC_W));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            v4_q      <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_p_q     <= '0;
        end else if (ce) begin
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            v3_q      <= v3_d;
            v4_q      <= v4_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_p_q     <= m_p_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            last1_q <= last1_d;
            wx0_q   <= wx0_d;
            wx1_q   <= wx1_d;
            wy0_q   <= wy0_d;
            wy1_q   <= wy1_d;
            px1_q   <= px1_d;
            last2_q <= last2_d;
            w2_q    <= w2_d;
            px2_q   <= px2_d;
            last3_q <= last3_d;
            prod_q  <= prod_d;
            last4_q <= last4_d;
            sum_q   <= sum_d;
        end
    end

endmodule

// File: tb/tb_interp_bilinear_pipe.sv
// tb/tb_interp_bilinear_pipe.sv - directed self-checking bench for interp_bilinear_pipe
module tb_interp_bilinear_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_last, s_mode, m_ready;
    logic [5:0]  dx, dy;
    logic [7:0]  lu, ru, ld, rd;
    logic [23:0] lu3, ru3, ld3, rd3;
    logic        s_ready, m_valid, m_last;
    logic [7:0]  m_p;
    logic        s_ready_t, m_valid_t, m_last_t;
    logic [7:0]  m_p_t;
    logic        s_ready_c, m_valid_c, m_last_c;
    logic [23:0] m_p_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    interp_bilinear_pipe #(.FRAC_W(6), .PIX_W(8), .CH(1), .ROUND(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .s_mode(s_mode), .dx(dx), .dy(dy), .lu(lu), .ru(ru), .ld(ld), .rd(rd),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_p(m_p));

    interp_bilinear_pipe #(.FRAC_W(6), .PIX_W(8), .CH(1), .ROUND(0)) u_trn (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_t), .s_last(s_last),
        .s_mode(s_mode), .dx(dx), .dy(dy), .lu(lu), .ru(ru), .ld(ld), .rd(rd),
        .m_valid(m_valid_t), .m_ready(m_ready), .m_last(m_last_t), .m_p(m_p_t));

    interp_bilinear_pipe #(.FRAC_W(6), .PIX_W(8), .CH(3), .ROUND(1)) u_rgb (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_c), .s_last(s_last),
        .s_mode(s_mode), .dx(dx), .dy(dy), .lu(lu3), .ru(ru3), .ld(ld3), .rd(rd3),
        .m_valid(m_valid_c), .m_ready(m_ready), .m_last(m_last_c), .m_p(m_p_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d,
                           input logic [5:0] x, input logic [5:0] y, input logic md,
                           input logic [7:0] er, input logic [7:0] et,
                           input logic chk_rgb, input logic [23:0] e3);
        lu = a; ru = b; ld = c; rd = d;
        dx = x; dy = y; s_mode = md; s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        #1;
        chk({tag, "_sready"}, 32'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (3) tick();
        chk({tag, "_early_valid"}, 32'(m_valid), 0);
        tick();
        chk({tag, "_valid"}, 32'(m_valid), 1);
        chk({tag, "_p_round"}, 32'(m_p), 32'(er));
        chk({tag, "_p_trunc"}, 32'(m_p_t), 32'(et));
        chk({tag, "_last"}, 32'(m_last), 1);
        if (chk_rgb) chk({tag, "_p_rgb"}, 32'(m_p_c), 32'(e3));
        tick();
        chk({tag, "_drained"}, 32'(m_valid), 0);
    endtask

    logic [5:0] bx [10];
    logic [5:0] by [10];
    logic [7:0] exp_r [10];
    logic [7:0] exp_t [10];
    int         idx_in, idx_out;
    logic       acc, fire, held, hold_last;
    logic [7:0] hold_p;

    initial begin
        bx    = '{0, 32, 63, 31, 0, 63, 32, 0, 63, 0};
        by    = '{0, 31, 0, 32, 63, 63, 32, 0, 63, 63};
        exp_r = '{10, 20, 20, 30, 30, 40, 25, 10, 40, 30};
        exp_t = '{10, 20, 19, 30, 29, 40, 25, 10, 39, 30};
        lu3 = {8'd255, 8'd100, 8'd0};
        ru3 = {8'd0, 8'd100, 8'd255};
        ld3 = {8'd0, 8'd100, 8'd255};
        rd3 = {8'd0, 8'd100, 8'd255};
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_mode = 1'b0; m_ready = 1'b1;
        dx = '0; dy = '0; lu = '0; ru = '0; ld = '0; rd = '0;

        repeat (3) tick();
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_last", 32'(m_last), 0);
        chk("rst_p", 32'(m_p), 0);
        chk("rst_sready", 32'(s_ready), 0);
        chk("rst_p_rgb", 32'(m_p_c), 0);
        rst_n = 1'b1;
        tick();

        run_one("corner00", 10, 20, 30, 40, 0, 0, 0, 10, 10, 0, 0);
        run_one("corner630", 10, 20, 30, 40, 63, 0, 0, 20, 19, 0, 0);
        run_one("corner063", 10, 20, 30, 40, 0, 63, 0, 30, 29, 0, 0);
        run_one("round_half", 0, 0, 0, 255, 32, 32, 0, 64, 63, 1, {8'd64, 8'd100, 8'd191});
        run_one("full_scale", 255, 255, 255, 255, 63, 63, 0, 255, 255, 0, 0);
        run_one("near_ru", 10, 20, 30, 40, 32, 31, 1, 20, 20, 0, 0);
        run_one("near_ld", 10, 20, 30, 40, 31, 32, 1, 30, 30, 0, 0);
        run_one("near_rd", 10, 20, 30, 40, 63, 63, 1, 40, 40, 0, 0);

        // ten back-to-back beats, alternating mode, downstream stalled in cycles 6-9
        lu = 10; ru = 20; ld = 30; rd = 40;
        idx_in = 0; idx_out = 0; held = 1'b0; hold_p = '0; hold_last = 1'b0;
        for (int cyc = 1; cyc <= 80 && idx_out < 10; cyc++) begin
            m_ready = !(cyc >= 6 && cyc <= 9);
            if (idx_in < 10) begin
                s_valid = 1'b1;
                s_mode  = idx_in[0];
                dx      = bx[idx_in];
                dy      = by[idx_in];
                s_last  = (idx_in == 9);
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b1;
            end
            #1;
            if (held) begin
                chk("bp_hold_valid", 32'(m_valid), 1);
                chk("bp_hold_p", 32'(m_p), 32'(hold_p));
                chk("bp_hold_last", 32'(m_last), 32'(hold_last));
            end
            if (cyc == 6) chk("bp_stall_has_output", 32'(m_valid), 1);
            if (cyc >= 6 && cyc <= 9) chk("bp_sready_stall", 32'(s_ready), 0);
            acc       = s_valid & s_ready;
            fire      = m_valid & m_ready;
            held      = m_valid & !m_ready;
            hold_p    = m_p;
            hold_last = m_last;
            if (fire) begin
                chk($sformatf("bp_out%0d_round", idx_out), 32'(m_p), 32'(exp_r[idx_out]));
                chk($sformatf("bp_out%0d_trunc", idx_out), 32'(m_p_t), 32'(exp_t[idx_out]));
                chk($sformatf("bp_out%0d_last", idx_out), 32'(m_last), 32'(idx_out == 9));
                idx_out++;
            end
            if (acc) idx_in++;
            tick();
        end
        chk("bp_out_count", 32'(idx_out), 10);
        chk("bp_in_count", 32'(idx_in), 10);
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        repeat (2) tick();
        chk("bp_no_extra", 32'(m_valid), 0);

        // reset with three beats in flight
        lu = 10; ru = 20; ld = 30; rd = 40; dx = 0; dy = 0; s_mode = 1'b0; s_valid = 1'b1;
        repeat (3) tick();
        s_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", 32'(m_valid), 0);
        chk("midrst_p", 32'(m_p), 0);
        chk("midrst_last", 32'(m_last), 0);
        chk("midrst_sready", 32'(s_ready), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("midrst_quiet%0d", i), 32'(m_valid), 0);
        end
        run_one("midrst_new", 10, 20, 30, 40, 63, 0, 0, 20, 19, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interp_bilinear_pipe.md
Name: interp_bilinear_pipe

Overview:
- Next-generation bilinear pixel interpolator for the rectification datapath.
- Takes four neighbour pixels and a fractional (dx, dy) offset per beat and returns one interpolated pixel per beat.
- Supports CH parallel channels (e.g. RGB), exact 2^F weight normalisation with optional rounding, a per-beat nearest-neighbour mode, and valid/ready backpressure.
- Sits between the coordinate/neighbour fetch stage and the output stream packer.

Parameters:
- FRAC_W, 6: fractional bits of dx/dy; weights are in units of 2^-FRAC_W.
- PIX_W, 8: bits per pixel channel.
- CH, 1: number of channels processed in lockstep; all channels share dx, dy and mode.
- ROUND, 1: 1 = round-half-up on normalisation; 0 = truncate.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept an input beat.
- s_last  in  1  end-of-line marker; travels with the beat.
- s_mode  in  1  0 = bilinear, 1 = nearest neighbour; travels with the beat.
- dx  in  FRAC_W  horizontal fraction, 0..2^FRAC_W-1.
- dy  in  FRAC_W  vertical fraction, 0..2^FRAC_W-1.
- lu  in  CH*PIX_W  upper-left neighbour; channel k is bits [k*PIX_W +: PIX_W].
- ru  in  CH*PIX_W  upper-right neighbour.
- ld  in  CH*PIX_W  lower-left neighbour.
- rd  in  CH*PIX_W  lower-right neighbour.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts the output beat.
- m_last  out  1  s_last of the beat currently on the output.
- m_p  out  CH*PIX_W  interpolated pixel, same channel packing as the inputs.

Behaviour:
- Reset: rst_n=0 at a clock edge clears every stage valid, m_valid, m_last and m_p to 0. s_ready is 0 while rst_n=0. Beats in flight are discarded and never appear on the output. Datapath registers other than m_p need not be reset.
- Stall enable: ce = !m_valid | m_ready. s_ready = ce whenever rst_n=1.
- An input beat is accepted when s_valid & s_ready.
- When ce=0, every pipeline register and the output hold their value.
- Valid bubbles advance through the pipeline like data. Throughput is 1 beat/cycle when m_ready stays high.
- Latency: a beat accepted at edge N is presented on m_valid/m_p after edge N+4 when no stall occurs. Each stalled cycle adds exactly 1 cycle.
- Stage 1 (weights): wx1 = dx, wx0 = 2^FRAC_W - dx, wy1 = dy, wy0 = 2^FRAC_W - dy, each FRAC_W+1 bits wide. Register pixels, mode and last alongside.
- Stage 2 (weight products), each 2*FRAC_W+2 bits: w_lu = wx0*wy0, w_ru = wx1*wy0, w_ld = wx0*wy1, w_rd = wx1*wy1. The four weights sum to exactly 2^(2*FRAC_W).
- Stage 3 (per channel): four pixel*weight products, each PIX_W+2*FRAC_W+2 bits.
- Stage 4 (per channel):
  - sum = the four products plus (ROUND ? 2^(2*FRAC_W-1) : 0).
  - Result = sum >> 2*FRAC_W, taking the low PIX_W bits.
  - The result is a convex combination, so it never exceeds the maximum neighbour value; no saturation logic is needed.
  - dx=0, dy=0 yields lu exactly.
- Nearest mode (s_mode=1): output the neighbour selected by hx = dx[FRAC_W-1] and hy = dy[FRAC_W-1].
  - hy=0, hx=0 selects lu; hy=0, hx=1 selects ru; hy=1, hx=0 selects ld; hy=1, hx=1 selects rd.
  - Latency is identical to bilinear mode (still 4).
  - Mode may change on any beat; no pipeline flush is needed.
- m_last is aligned with its own beat's m_p. s_last with s_valid=0 is ignored.
- m_valid, m_last and m_p are stable while m_valid=1 and m_ready=0.
- Simultaneous m_ready rising and new input: the output advances and the input is accepted at the same edge.
- m_ready=1 with m_valid=0 has no effect other than ce=1.

Test Plan:
- Corner weights, FRAC_W=6, CH=1: lu=10, ru=20, ld=30, rd=40 with (dx,dy) = (0,0), (63,0), (0,63) in turn -> m_p = 10, then 20 (19.84 rounded), then 30 (29.69 rounded); each appears exactly 4 cycles after acceptance.
- Rounding: lu=ru=ld=0, rd=255, dx=dy=32 -> ROUND=1 gives m_p=64; ROUND=0 gives m_p=63. Also all neighbours 255, dx=dy=63 -> m_p=255 with no overflow.
- Nearest mode, same pixels 10/20/30/40: (dx,dy) = (32,31) gives 20, (31,32) gives 30, (63,63) gives 40. Interleave mode 0/1 on consecutive beats and check each result against its own mode.
- Backpressure: 10 back-to-back beats with the last on beat 10; hold m_ready=0 for cycles 6-9 -> s_ready=0 during the stall, all 10 outputs in order with none lost or duplicated, output held stable while stalled, m_last only on output 10.
- CH=3 (RGB): lu = {R=0, G=100, B=255}, all other neighbours {255, 100, 0}, dx=dy=32 -> per-channel results {191, 100, 64} (ROUND=1), packed R in the LSBs.
- Reset mid-stream: pull rst_n low for 1 cycle with 3 beats in flight -> m_valid=0 and m_p=0 after that edge, no stale beat ever emerges, and a new beat accepted afterwards appears 4 cycles later.
